cube_scan_driver: RTL

Consumes the flat 8×8×8 frame (`frame_cube_flat` plus its one-cycle `frame_valid` strobe) from the frame generator and drives the physical LED cube. It double-buffers the frame so the display never tears. It scans the cube one layer at a time: for each layer it serially shifts 64 column bits into the external 74HC595 chain, latches them, and enables that layer's driver.

---
 rtl/cube_pkg.sv | 16 +
 rtl/col_shifter.sv | 59 +++++
 rtl/cube_scan_driver.sv | 96 +++++++++
 3 files changed

// File: rtl/cube_pkg.sv
// rtl/cube_pkg.sv - cube geometry constants and scan FSM encoding shared by the cube driver
package cube_pkg;
  localparam int CUBE_N_LAYER = 8;
  localparam int CUBE_N_COL   = 64;
  localparam int CUBE_FRAME_W = 512;

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    LATCH = 2'd1,
    HOLD  = 2'd2
  } scan_state_t;

  function automatic logic [CUBE_N_LAYER-1:0] layer_onehot(input logic [2:0] layer);
    return {{(CUBE_N_LAYER-1){1'b0}}, 1'b1} << layer;
  endfunction
endpackage

// File: rtl/col_shifter.sv
// rtl/col_shifter.sv - serialises one 64-column layer word (column 63 first) onto ser_data/ser_clk
module col_shifter
  import cube_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CUBE_N_COL-1:0] word,
  output logic                  ser_data,
  output logic                  ser_clk,
  output logic                  last,
  output logic                  done
);
  localparam int DW = $clog2(CLK_DIV + 1);

  logic [CUBE_N_COL-1:0] sr;
  logic [5:0]            bit_cnt;
  logic [DW-1:0]         div_cnt;
  logic                  busy;
  logic                  half_end;

  assign half_end = busy && (div_cnt == DW'(CLK_DIV - 1));
  assign last     = half_end && ser_clk && (bit_cnt == 6'd63);
  assign ser_data = sr[CUBE_N_COL-1];

  // Out of reset the shifter is already running on an all-zero word, so layer 0
  // starts shifting in the very first cycle without needing a start pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      busy    <= 1'b1;
      ser_clk <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= last;
      if (start) begin
        sr      <= word;
        bit_cnt <= '0;
        div_cnt <= '0;
        busy    <= 1'b1;
        ser_clk <= 1'b0;
      end else if (busy) begin
        div_cnt <= half_end ? '0 : div_cnt + DW'(1);
        if (half_end) begin
          ser_clk <= ~ser_clk;
          if (ser_clk) begin
            sr      <= {sr[CUBE_N_COL-2:0], 1'b0};
            bit_cnt <= bit_cnt + 6'd1;
            if (last) busy <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: rtl/cube_scan_driver.sv
// rtl/cube_scan_driver.sv - double-buffered 8x8x8 LED cube layer scanner; CUBE_BLANK_EN blanks layers during SHIFT/LATCH
module cube_scan_driver
  import cube_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CUBE_FRAME_W-1:0] frame_cube_flat,
  input  logic                    frame_valid,
  output logic                    ser_data,
  output logic                    ser_clk,
  output logic                    ser_latch,
  output logic [CUBE_N_LAYER-1:0] layer_sel,
  output logic                    frame_swapped
);
  localparam int HW = (DWELL > 1) ? $clog2(DWELL) : 1;

  scan_state_t             state, state_n;
  logic [2:0]              layer;
  logic [2:0]              next_layer;
  logic [HW-1:0]           hold_cnt;
  logic [CUBE_N_LAYER-1:0] sel_q;
  logic [CUBE_FRAME_W-1:0] pend, disp;
  logic                    pend_valid;
  logic                    start, swap, shift_last;
  logic [CUBE_N_COL-1:0]   shift_word;

  assign next_layer = layer + 3'd1;
  // Layer L's 64 columns are the contiguous bits [L*64 +: 64]; on a swap the
  // first word must come from the frame about to become displayed.
  assign shift_word = swap ? pend[CUBE_N_COL-1:0] : disp[{next_layer, 6'd0} +: CUBE_N_COL];

  col_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .word     (shift_word),
    .ser_data (ser_data),
    .ser_clk  (ser_clk),
    .last     (shift_last),
    .done     (ser_latch)
  );

  always_comb begin
    state_n = state;
    start   = 1'b0;
    swap    = 1'b0;
    unique case (state)
      SHIFT: if (shift_last) state_n = LATCH;
      LATCH: state_n = HOLD;
      HOLD: begin
        if (hold_cnt == HW'(DWELL - 1)) begin
          state_n = SHIFT;
          start   = 1'b1;
          swap    = (layer == 3'd7) && pend_valid;
        end
      end
      default: state_n = SHIFT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= SHIFT;
      layer         <= '0;
      hold_cnt      <= '0;
      sel_q         <= '0;
      pend          <= '0;
      disp          <= '0;
      pend_valid    <= 1'b0;
      frame_swapped <= 1'b0;
    end else begin
      state         <= state_n;
      frame_swapped <= swap;
      hold_cnt      <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
      if (start) layer <= next_layer;
      if (state == LATCH) sel_q <= layer_onehot(layer);
      if (swap) disp <= pend;
      // A strobe coinciding with the swap lands in pend after disp took the old one.
      if (frame_valid) begin
        pend       <= frame_cube_flat;
        pend_valid <= 1'b1;
      end else if (swap) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef CUBE_BLANK_EN
  assign layer_sel = (state == HOLD) ? sel_q : '0;
`else
  assign layer_sel = (state == LATCH) ? layer_onehot(layer) : sel_q;
`endif
endmodule
